// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and default widths.
package program_loader_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 4;
  localparam int DEFAULT_DATA_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PROG  = 2'd1,
    ST_WRITE = 2'd2,
    ST_EXIT  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/button_debouncer.sv
// Debounces one raw button: emits a single-cycle press event once the input has
// been sampled high DEBOUNCE_CYCLES times in a row, then stays quiet until release.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic rawIn,
  output logic pressEvent
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             event_q, event_d;

  // Count consecutive high samples, saturating so a held button fires only once.
  always_comb begin
    cnt_d   = '0;
    event_d = 1'b0;
    if (rawIn) begin
      cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      event_d = (cnt_q == CNT_FIRE);
    end
  end

  // Counter and registered event pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      event_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      event_q <= event_d;
    end
  end

  assign pressEvent = event_q;

endmodule

// File: rtl/program_loader.sv
// Front-panel program loader: writable program memory read live by the CPU,
// filled one opcode per debounced load press while the CPU is held.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ADDR_WIDTH      = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  progBtn,
  input  logic                  loadBtn,
  input  logic                  doneBtn,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic [ADDR_WIDTH-1:0] rdAddr,
  output logic [DATA_WIDTH-1:0] rdData,
  output logic                  cpuHold,
  output logic                  cpuRestart,
  output logic [ADDR_WIDTH-1:0] progAddr
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  // Button order: bit 0 = prog, bit 1 = load, bit 2 = done.
  logic [2:0] btn_raw;
  logic [2:0] btn_evt;
  assign btn_raw = {doneBtn, loadBtn, progBtn};

  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk       (clk),
      .reset     (reset),
      .rawIn     (btn_raw[gi]),
      .pressEvent(btn_evt[gi])
    );
  end

  logic prog_evt, load_evt, done_evt;
  assign prog_evt = btn_evt[0];
  assign load_evt = btn_evt[1];
  assign done_evt = btn_evt[2];

  loader_state_e                  state_q, state_d;
  logic          [ADDR_WIDTH-1:0] prog_addr_q, prog_addr_d;
  logic                           write_en;
  logic          [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic          [DATA_WIDTH-1:0] mem_d [DEPTH];

  // Loader next-state logic; done beats load when both arrive together.
  always_comb begin
    state_d     = state_q;
    prog_addr_d = prog_addr_q;
    write_en    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (prog_evt) begin
          state_d     = ST_PROG;
          prog_addr_d = '0;
        end
      end
      ST_PROG: begin
        if (done_evt) begin
          state_d = ST_EXIT;
        end else if (load_evt) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        write_en    = 1'b1;
        prog_addr_d = prog_addr_q + 1'b1;
        state_d     = (prog_addr_q == LAST_ADDR) ? ST_EXIT : ST_PROG;
      end
      ST_EXIT: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Memory next value: only the addressed word changes during WRITE.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (write_en) begin
      mem_d[prog_addr_q] = dataIn;
    end
  end

  // State, write pointer and memory registers; reset clears the whole program.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      prog_addr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      prog_addr_q <= prog_addr_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign cpuHold    = (state_q != ST_RUN);
  assign cpuRestart = (state_q == ST_EXIT);
  assign progAddr   = prog_addr_q;
  assign rdData     = mem_q[rdAddr];

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed scenarios plus random button traffic,
// all checked cycle by cycle against a behavioural model of the loader.
module tb_program_loader;

  localparam int N     = 4;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] btn;
  logic [3:0] dataIn;
  logic [3:0] rdAddr;
  logic [3:0] rdData;
  logic       cpuHold;
  logic       cpuRestart;
  logic [3:0] progAddr;

  always #5 clk = ~clk;

  program_loader #(
    .DEBOUNCE_CYCLES(N),
    .ADDR_WIDTH     (4),
    .DATA_WIDTH     (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .progBtn   (btn[0]),
    .loadBtn   (btn[1]),
    .doneBtn   (btn[2]),
    .dataIn    (dataIn),
    .rdAddr    (rdAddr),
    .rdData    (rdData),
    .cpuHold   (cpuHold),
    .cpuRestart(cpuRestart),
    .progAddr  (progAddr)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: run lengths of high samples per button, a pending
  // accepted press, and the loader's mode flags, write pointer and memory image.
  int run_len [3];
  bit pend    [3];
  bit holding;
  bit write_now;
  bit restart_now;
  int addr;
  int mem_m [DEPTH];
  int restart_seen = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit evt [3];
    if (reset) begin
      for (int b = 0; b < 3; b++) begin
        run_len[b] = 0;
        pend[b]    = 1'b0;
      end
      holding     = 1'b0;
      write_now   = 1'b0;
      restart_now = 1'b0;
      addr        = 0;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = 0;
      return;
    end
    for (int b = 0; b < 3; b++) begin
      evt[b]     = pend[b];
      run_len[b] = btn[b] ? run_len[b] + 1 : 0;
      pend[b]    = btn[b] && (run_len[b] == N);
    end
    if (restart_now) begin
      restart_now = 1'b0;
      holding     = 1'b0;
    end else if (write_now) begin
      mem_m[addr] = int'(dataIn);
      $display("write addr=%0d data=%0h", addr, dataIn);
      addr      = (addr + 1) % DEPTH;
      write_now = 1'b0;
      if (addr == 0) restart_now = 1'b1;
    end else if (holding) begin
      if (evt[2]) restart_now = 1'b1;
      else if (evt[1]) write_now = 1'b1;
    end else if (evt[0]) begin
      holding = 1'b1;
      addr    = 0;
    end
  endtask

  // One clock: update the model at the edge, compare all outputs mid-cycle.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_val("cpuHold", cpuHold, holding);
    check_val("cpuRestart", cpuRestart, restart_now);
    check_val("progAddr", progAddr, addr);
    check_val("rdData", rdData, mem_m[rdAddr]);
    if (cpuRestart) restart_seen++;
    rdAddr = 4'($urandom_range(0, 15));
  endtask

  task automatic press(input logic [2:0] mask, input int hi, input int lo);
    btn = mask;
    repeat (hi) step();
    btn = 3'b000;
    repeat (lo) step();
  endtask

  task automatic read_check(input string tag, input int a, input int exp);
    rdAddr = 4'(a);
    #1;
    check_val(tag, rdData, exp);
  endtask

  int rs0;
  int vals [3];

  initial begin
    reset  = 1'b1;
    btn    = 3'b000;
    dataIn = 4'h0;
    rdAddr = 4'h0;

    // 1: reset state and cleared memory
    repeat (2) step();
    reset = 1'b0;
    step();
    check_val("rst_hold", cpuHold, 0);
    check_val("rst_restart", cpuRestart, 0);
    check_val("rst_addr", progAddr, 0);
    for (int a = 0; a < DEPTH; a++) read_check("rst_mem", a, 0);

    // 2: short load press is rejected
    press(3'b001, N, 2);
    check_val("prog_hold", cpuHold, 1);
    dataIn = 4'hC;
    press(3'b010, N - 1, 3);
    check_val("short_addr", progAddr, 0);
    read_check("short_mem0", 0, 0);
    press(3'b100, N, 4);

    // 3: three loads then done
    vals[0] = 3; vals[1] = 5; vals[2] = 'hA;
    press(3'b001, N, 2);
    for (int i = 0; i < 3; i++) begin
      dataIn = 4'(vals[i]);
      press(3'b010, N, 3);
    end
    check_val("three_addr", progAddr, 3);
    rs0 = restart_seen;
    press(3'b100, N, 3);
    check_val("three_restart_cnt", restart_seen - rs0, 1);
    check_val("three_hold_after", cpuHold, 0);
    read_check("three_mem0", 0, 3);
    read_check("three_mem1", 1, 5);
    read_check("three_mem2", 2, 'hA);

    // 4: sixteen loads fill memory and exit automatically
    press(3'b001, N, 2);
    rs0 = restart_seen;
    for (int i = 0; i < DEPTH; i++) begin
      dataIn = 4'((i + 1) % DEPTH);
      press(3'b010, N, 3);
    end
    check_val("full_restart_cnt", restart_seen - rs0, 1);
    check_val("full_addr", progAddr, 0);
    check_val("full_hold", cpuHold, 0);
    read_check("full_mem15", 15, 0);
    read_check("full_mem4", 4, 5);

    // 5: reset mid-programming
    press(3'b001, N, 2);
    dataIn = 4'h7; press(3'b010, N, 3);
    dataIn = 4'h9; press(3'b010, N, 3);
    rs0   = restart_seen;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_val("midrst_hold", cpuHold, 0);
    check_val("midrst_restart", cpuRestart, 0);
    read_check("midrst_mem0", 0, 0);
    read_check("midrst_mem1", 1, 0);
    step();
    check_val("midrst_restart_cnt", restart_seen - rs0, 0);

    // 6: load and done together -> exit without write
    press(3'b001, N, 2);
    dataIn = 4'h6; press(3'b010, N, 3);
    rs0 = restart_seen;
    dataIn = 4'hE;
    press(3'b110, N, 3);
    check_val("both_restart_cnt", restart_seen - rs0, 1);
    check_val("both_addr", progAddr, 1);
    read_check("both_mem1", 1, 0);
    read_check("both_mem0", 0, 6);

    // 7: random button traffic
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end
      dataIn = 4'($urandom_range(0, 15));
      btn    = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) btn = 3'b000;
      repeat ($urandom_range(1, 7)) step();
    end
    btn = 3'b000;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Writer side of the CPU's program store: a 16x4 writable program memory plus a front-panel loader FSM.
- The operator enters program mode, keys opcodes on the switches and strobes each into consecutive addresses, then releases the CPU.
- During programming the block holds the CPU (PC enable gated). On exit it pulses a restart so execution begins at address 0.
- It replaces the fixed program ROM on the CPU's read path: the PC drives rdAddr and rdData feeds the instruction decoder.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive high samples required to accept a button press (board build overrides, e.g. 250000).
ADDR_WIDTH, 4, program address width; depth = 2**ADDR_WIDTH.
DATA_WIDTH, 4, opcode width.

Ports:
clk  in  1  system clock; one clock domain.
reset  in  1  synchronous, active-high reset.
progBtn  in  1  raw button: enter program mode.
loadBtn  in  1  raw button: write dataIn at current address.
doneBtn  in  1  raw button: leave program mode.
dataIn  in  DATA_WIDTH  opcode to write (switches[3:0]).
rdAddr  in  ADDR_WIDTH  CPU fetch address (PC).
rdData  out  DATA_WIDTH  combinational read, mem[rdAddr].
cpuHold  out  1  high while programming; CPU PC enable = ~cpuHold.
cpuRestart  out  1  one-cycle pulse to reset the CPU PC/ACC on exit.
progAddr  out  ADDR_WIDTH  next write address (for display).

Behaviour:
- Reset (sampled on rising clk while reset=1):
  - state=RUN; cpuHold=0, cpuRestart=0, progAddr=0.
  - All memory words = 0. Debouncer counters = 0.
- Debounce (per button):
  - Counter increments while the raw input is high and clears when it is low.
  - A press event fires for exactly one cycle when the counter reaches DEBOUNCE_CYCLES.
  - No further event fires until the input has returned low.
  - The event is visible to the FSM DEBOUNCE_CYCLES cycles after the first high sample.
- FSM states: RUN, PROG, WRITE, EXIT.
  - RUN: cpuHold=0. A prog event moves to PROG, sets progAddr=0 and raises cpuHold in the same transition. load/done events are ignored.
  - PROG: cpuHold=1.
    - done event -> EXIT.
    - else load event -> WRITE.
    - done and load in the same cycle: done wins and the load is discarded.
    - prog event is ignored.
  - WRITE (one cycle): mem[progAddr] <= dataIn sampled this cycle; progAddr <= progAddr+1 (wraps).
    - If progAddr was 2**ADDR_WIDTH-1 (memory full) -> EXIT; else -> PROG.
  - EXIT (one cycle): cpuRestart=1, cpuHold=1, then -> RUN with cpuHold=0 and cpuRestart=0.
- Read port:
  - Always combinational and live, including in program mode.
  - A read of the address being written returns the old value in the WRITE cycle and the new value the cycle after.
- Reset mid-programming: immediately returns to RUN, memory cleared, no cpuRestart pulse (the CPU shares the reset).
- Widths: progAddr wraps modulo 2**ADDR_WIDTH; no overflow flag.

Decomposition:
- Shared package: FSM state encoding (RUN=2'd0, PROG=2'd1, WRITE=2'd2, EXIT=2'd3), default ADDR_WIDTH/DATA_WIDTH constants.
- Sub-module: button_debouncer (clk, reset, rawIn, pressEvent; DEBOUNCE_CYCLES), instantiated three times.
- Memory array and FSM live in program_loader.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4.
1. Reset -> cpuHold=0, cpuRestart=0, progAddr=0; rdData=0 for rdAddr 0..15.
2. Enter program mode, loadBtn high for 3 cycles then low -> no write; progAddr stays 0; mem[0]=0.
3. Program entry, loads of 0x3, 0x5, 0xA, then done:
   - mem[0..2] = 3, 5, A; progAddr=3 before done.
   - cpuRestart high for exactly one cycle; cpuHold low the cycle after.
   - rdAddr=1 -> rdData=5.
4. Sixteen loads of 0x1..0xF,0x0 without done -> auto EXIT after the 16th write; cpuRestart pulses once; progAddr=0; mem[15]=0, mem[4]=5.
5. Reset asserted mid-programming after 2 writes -> next cycle state RUN, cpuHold=0, mem[0]=mem[1]=0, no cpuRestart.
6. In PROG, load and done events in the same cycle -> EXIT taken, no write, progAddr unchanged.
